mem_arbiter: RTL and testbench

- Two-requester arbiter for the single shared memory port of mips_mem.
- Requester C is the MIPS core; requester D is a DMA/boot loader that preloads programs and dumps results.
- Registered ownership FSM with round-robin fairness and a bounded burst hold. One memory beat per cycle, read data valid one cycle after the beat.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and mailbox signals of the two-requester
// memory arbiter.
//   c_* / d_*   core / DMA requester: req, we, adr, wd in; gnt, rvalid out
//   rdata       read data returned to whichever requester has rvalid
//   mem_*       shared memory port (adr, wd, we, re out; rd in)
//   mbox_*      mailbox status (tied to 0 unless the mailbox is built in)
// Modport slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             c_req, c_we, c_gnt, c_rvalid;
    logic [WIDTH-1:0] c_adr, c_wd;
    logic             d_req, d_we, d_gnt, d_rvalid;
    logic [WIDTH-1:0] d_adr, d_wd;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] mem_adr, mem_wd, mem_rd;
    logic             mem_we, mem_re;
    logic             mbox_valid;
    logic [WIDTH-1:0] mbox_data;

    modport slave (
        input  c_req, c_we, c_adr, c_wd,
        input  d_req, d_we, d_adr, d_wd,
        input  mem_rd,
        output c_gnt, c_rvalid, d_gnt, d_rvalid, rdata,
        output mem_adr, mem_wd, mem_we, mem_re,
        output mbox_valid, mbox_data
    );

    modport master (
        output c_req, c_we, c_adr, c_wd,
        output d_req, d_we, d_adr, d_wd,
        output mem_rd,
        input  c_gnt, c_rvalid, d_gnt, d_rvalid, rdata,
        input  mem_adr, mem_wd, mem_we, mem_re,
        input  mbox_valid, mbox_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single memory port between the MIPS core (C)
// and a DMA/boot loader (D). Registered ownership FSM, round-robin on
// simultaneous requests from idle, and a burst limit of MAX_BURST beats per
// owner while the other side waits. One beat per cycle; read data and rvalid
// arrive the cycle after the beat.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    mem_arbiter_if.slave (requesters, memory port, mailbox)
// Build option MEM_ARBITER_MAILBOX_EN: address all-ones becomes a one-word
// mailbox register instead of memory (writes latch mbox_data and set sticky
// mbox_valid; reads return mbox_data). Without it, mbox_* are tied to 0.
module mem_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {NONE = 2'd0, OWN_C = 2'd1, OWN_D = 2'd2} owner_t;

    localparam logic [3:0] LP_LAST = 4'(MAX_BURST - 1);

    owner_t           r_owner, w_owner_nxt;
    logic             r_rr;             // 0 = C wins next tie, 1 = D
    logic [3:0]       r_cnt;
    logic             r_rv_c, r_rv_d;
    logic             w_c_gnt, w_d_gnt, w_gnt, w_we, w_mbox_hit;
    logic [WIDTH-1:0] w_adr, w_wd;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= NONE;
            r_rr    <= 1'b0;
            r_cnt   <= 4'd0;
            r_rv_c  <= 1'b0;
            r_rv_d  <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            if (w_owner_nxt != r_owner)
                r_cnt <= 4'd0;
            else if (w_gnt && r_cnt != 4'hF)
                r_cnt <= r_cnt + 4'd1;
            // The side just left loses the next tie.
            if (r_owner == OWN_C && w_owner_nxt != OWN_C)
                r_rr <= 1'b1;
            else if (r_owner == OWN_D && w_owner_nxt != OWN_D)
                r_rr <= 1'b0;
            r_rv_c <= w_c_gnt & ~bus.c_we;
            r_rv_d <= w_d_gnt & ~bus.d_we;
        end
    end

    // Next-state logic
    always_comb begin
        w_owner_nxt = r_owner;
        case (r_owner)
            NONE: begin
                if (bus.c_req && bus.d_req) w_owner_nxt = r_rr ? OWN_D : OWN_C;
                else if (bus.c_req)         w_owner_nxt = OWN_C;
                else if (bus.d_req)         w_owner_nxt = OWN_D;
            end
            OWN_C: begin
                if (!bus.c_req)
                    w_owner_nxt = bus.d_req ? OWN_D : NONE;
                else if (bus.d_req && r_cnt == LP_LAST)
                    w_owner_nxt = OWN_D;
            end
            OWN_D: begin
                if (!bus.d_req)
                    w_owner_nxt = bus.c_req ? OWN_C : NONE;
                else if (bus.c_req && r_cnt == LP_LAST)
                    w_owner_nxt = OWN_C;
            end
            default: w_owner_nxt = NONE;
        endcase
    end

    // Outputs: grants and the memory-port mux
    always_comb begin
        w_c_gnt = (r_owner == OWN_C) & bus.c_req;
        w_d_gnt = (r_owner == OWN_D) & bus.d_req;
        w_gnt   = w_c_gnt | w_d_gnt;
        w_we    = 1'b0;
        w_adr   = '0;
        w_wd    = '0;
        if (w_c_gnt) begin
            w_we  = bus.c_we;
            w_adr = bus.c_adr;
            w_wd  = bus.c_wd;
        end else if (w_d_gnt) begin
            w_we  = bus.d_we;
            w_adr = bus.d_adr;
            w_wd  = bus.d_wd;
        end
`ifdef MEM_ARBITER_MAILBOX_EN
        w_mbox_hit = w_gnt & (w_adr == {WIDTH{1'b1}});
`else
        w_mbox_hit = 1'b0;
`endif
        bus.c_gnt    = w_c_gnt;
        bus.d_gnt    = w_d_gnt;
        bus.mem_adr  = w_adr;
        bus.mem_wd   = w_wd;
        // Mailbox beats never reach memory.
        bus.mem_we   = w_gnt &  w_we & ~w_mbox_hit;
        bus.mem_re   = w_gnt & ~w_we & ~w_mbox_hit;
        bus.c_rvalid = r_rv_c;
        bus.d_rvalid = r_rv_d;
    end

`ifdef MEM_ARBITER_MAILBOX_EN
    logic             r_mbox_valid, r_mbox_rd;
    logic [WIDTH-1:0] r_mbox_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mbox_valid <= 1'b0;
            r_mbox_data  <= '0;
            r_mbox_rd    <= 1'b0;
        end else begin
            // Remembers that next cycle's rdata must come from the mailbox.
            r_mbox_rd <= w_mbox_hit & ~w_we;
            if (w_mbox_hit && w_we) begin
                r_mbox_valid <= 1'b1;
                r_mbox_data  <= w_wd;
            end
        end
    end

    assign bus.rdata      = r_mbox_rd ? r_mbox_data : bus.mem_rd;
    assign bus.mbox_valid = r_mbox_valid;
    assign bus.mbox_data  = r_mbox_data;
`else
    assign bus.rdata      = bus.mem_rd;
    assign bus.mbox_valid = 1'b0;
    assign bus.mbox_data  = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
`ifdef MEM_ARBITER_MAILBOX_EN
    localparam bit MBOX = 1'b1;
`else
    localparam bit MBOX = 1'b0;
`endif

    typedef struct packed {
        logic       is_d;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(WIDTH)) bus();
    mem_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Memory model: pattern adr ^ 0x1D, read data one cycle after mem_re.
    logic [7:0] mem [256];
    logic [7:0] mem_rd_r = 8'h00;
    logic       mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h1D;
            mem_init <= 1'b1;
        end else begin
            if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_wd;
            if (bus.mem_re) mem_rd_r <= mem[bus.mem_adr];
        end
    end
    assign bus.mem_rd = mem_rd_r;

    // Scoreboard: push expected read data on a read grant (from the bench's
    // own view of memory/mailbox), pop and compare on rvalid.
    logic [7:0] exp_mem [256];
    logic [7:0] exp_mbox = 8'h00;
    bit         exp_init = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!exp_init) begin
            for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h1D;
            exp_init = 1'b1;
        end
        if (reset) begin
            exp_mbox = 8'h00;
        end else begin
            if (bus.c_rvalid || bus.d_rvalid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_rvalid c_rvalid=%0b d_rvalid=%0b", bus.c_rvalid, bus.d_rvalid);
                end else begin
                    e = sb.pop_front();
                    if (bus.d_rvalid !== e.is_d || bus.c_rvalid !== ~e.is_d || bus.rdata !== e.data) begin
                        errors++;
                        $display("FAIL sb_read got d=%0b c=%0b rdata=%h exp d=%0b rdata=%h",
                                 bus.d_rvalid, bus.c_rvalid, bus.rdata, e.is_d, e.data);
                    end
                end
            end
            checks++;
            if (bus.c_gnt === 1'b1 && bus.d_gnt === 1'b1) begin
                errors++;
                $display("FAIL both_grants got c_gnt=1 d_gnt=1 exp at most one");
            end
            if (bus.c_gnt) begin
                if (bus.c_we) begin
                    if (MBOX && bus.c_adr == 8'hFF) exp_mbox = bus.c_wd;
                    else exp_mem[bus.c_adr] = bus.c_wd;
                end else
                    sb.push_back({1'b0, (MBOX && bus.c_adr == 8'hFF) ? exp_mbox : exp_mem[bus.c_adr]});
            end
            if (bus.d_gnt) begin
                if (bus.d_we) begin
                    if (MBOX && bus.d_adr == 8'hFF) exp_mbox = bus.d_wd;
                    else exp_mem[bus.d_adr] = bus.d_wd;
                end else
                    sb.push_back({1'b1, (MBOX && bus.d_adr == 8'hFF) ? exp_mbox : exp_mem[bus.d_adr]});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; bus.c_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.d_gnt, bus.mem_we, bus.mem_re} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got gnt=%b%b we=%b re=%b exp 0", bus.c_gnt, bus.d_gnt, bus.mem_we, bus.mem_re);
        end
        checks++;
        if ({bus.c_rvalid, bus.d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid got %b%b exp 00", bus.c_rvalid, bus.d_rvalid);
        end
        checks++;
        if (bus.mbox_valid !== 1'b0 || bus.mbox_data !== 8'h00 || bus.mem_adr !== 8'h00) begin
            errors++;
            $display("FAIL reset_mbox got valid=%b data=%h adr=%h exp 0", bus.mbox_valid, bus.mbox_data, bus.mem_adr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_core_read();
        @(posedge clk); #1;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 8'h10;
        @(negedge clk);
        checks++;
        if (bus.c_gnt !== 1'b0) begin errors++; $display("FAIL core_read_early_gnt got %b exp 0", bus.c_gnt); end
        @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.d_gnt, bus.mem_re, bus.mem_we} !== 4'b1010 || bus.mem_adr !== 8'h10) begin
            errors++;
            $display("FAIL core_read_beat got c_gnt=%b d_gnt=%b re=%b we=%b adr=%h exp 1 0 1 0 10",
                     bus.c_gnt, bus.d_gnt, bus.mem_re, bus.mem_we, bus.mem_adr);
        end
        @(posedge clk); #1;
        bus.c_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.c_rvalid !== 1'b1 || bus.rdata !== 8'h0D || bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_data got rvalid=%b rdata=%h exp 1 0d", bus.c_rvalid, bus.rdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        do_reset();
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 8'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 8'h30;
        @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.d_gnt} !== 2'b00) begin errors++; $display("FAIL contention_idle got %b%b exp 00", bus.c_gnt, bus.d_gnt); end
        for (int i = 0; i < 4 * MAX_BURST; i++) begin
            logic exp_c;
            @(negedge clk);
            exp_c = ((i / MAX_BURST) % 2) == 0;
            checks++;
            if (bus.c_gnt !== exp_c || bus.d_gnt !== ~exp_c) begin
                errors++;
                $display("FAIL contention_beat%0d got c=%b d=%b exp c=%b d=%b", i, bus.c_gnt, bus.d_gnt, exp_c, ~exp_c);
            end
        end
        @(posedge clk); #1;
        bus.c_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_owner_drop();
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 8'h40;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL drop_d_beat1 got %b exp 1", bus.d_gnt); end
        @(posedge clk); #1;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 8'h50;
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.c_gnt} !== 2'b10) begin errors++; $display("FAIL drop_d_beat2 got d=%b c=%b exp 1 0", bus.d_gnt, bus.c_gnt); end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.c_gnt} !== 2'b00) begin errors++; $display("FAIL drop_gap got d=%b c=%b exp 0 0", bus.d_gnt, bus.c_gnt); end
        @(negedge clk);
        checks++;
        if (bus.c_gnt !== 1'b1) begin errors++; $display("FAIL drop_c_takes got %b exp 1", bus.c_gnt); end
        @(posedge clk); #1;
        bus.d_req = 1'b1;
        // C started with a cleared count, so it keeps MAX_BURST beats in total.
        for (int i = 1; i < MAX_BURST; i++) begin
            @(negedge clk);
            checks++;
            if (bus.c_gnt !== 1'b1) begin errors++; $display("FAIL drop_c_burst%0d got %b exp 1", i, bus.c_gnt); end
        end
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.c_gnt} !== 2'b10) begin errors++; $display("FAIL drop_switch got d=%b c=%b exp 1 0", bus.d_gnt, bus.c_gnt); end
        @(posedge clk); #1;
        bus.c_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 8'h60;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got %b exp 1", bus.d_gnt); end
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.d_rvalid, bus.d_gnt, bus.c_gnt, bus.mem_re, bus.mem_we} !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_state got rvalid=%b gnt=%b%b re=%b we=%b exp 0",
                     bus.d_rvalid, bus.d_gnt, bus.c_gnt, bus.mem_re, bus.mem_we);
        end
        #1;
        sb.delete();
        reset = 1'b0;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 8'h70;
        @(negedge clk);
        checks++;
        if ({bus.c_gnt, bus.d_gnt} !== 2'b10) begin errors++; $display("FAIL midrst_c_first got c=%b d=%b exp 1 0", bus.c_gnt, bus.d_gnt); end
        @(posedge clk); #1;
        bus.c_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mailbox();
        do_reset();
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_adr = 8'hFF; bus.c_wd = 8'h0D;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.c_gnt !== 1'b1) begin errors++; $display("FAIL mbox_wr_gnt got %b exp 1", bus.c_gnt); end
        checks++;
        if (MBOX) begin
            if ({bus.mem_we, bus.mem_re} !== 2'b00) begin errors++; $display("FAIL mbox_wr_blocked got we=%b re=%b exp 0 0", bus.mem_we, bus.mem_re); end
        end else begin
            if (bus.mem_we !== 1'b1 || bus.mem_adr !== 8'hFF || bus.mem_wd !== 8'h0D) begin
                errors++;
                $display("FAIL mbox_wr_passthru got we=%b adr=%h wd=%h exp 1 ff 0d", bus.mem_we, bus.mem_adr, bus.mem_wd);
            end
        end
        @(posedge clk); #1;
        bus.c_req = 1'b0; bus.c_we = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mbox_valid !== MBOX || bus.mbox_data !== (MBOX ? 8'h0D : 8'h00)) begin
            errors++;
            $display("FAIL mbox_regs got valid=%b data=%h exp valid=%b", bus.mbox_valid, bus.mbox_data, MBOX);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_re !== ~MBOX) begin
            errors++;
            $display("FAIL mbox_rd_beat got gnt=%b re=%b exp 1 %b", bus.d_gnt, bus.mem_re, ~MBOX);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.rdata !== 8'h0D) begin
            errors++;
            $display("FAIL mbox_rd_data got rvalid=%b rdata=%h exp 1 0d", bus.d_rvalid, bus.rdata);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_adr = 8'h00; bus.c_wd = 8'h00;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_adr = 8'h00; bus.d_wd = 8'h00;
        test_reset();
        test_core_read();
        test_contention();
        test_owner_drop();
        test_reset_mid_read();
        test_mailbox();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end
endmodule
